// File: rtl/adpcm_nibble_feeder_if.sv
// Byte stream handshake between the ADPCM byte source and the nibble feeder.
interface adpcm_nibble_feeder_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_last;
  logic       byte_ready;

  modport master (output byte_data, output byte_valid, output byte_last, input byte_ready);
  modport slave  (input byte_data, input byte_valid, input byte_last, output byte_ready);
endinterface

// File: rtl/adpcm_nibble_feeder.sv
// ADPCM nibble feeder: buffers packed ADPCM bytes and strobes one 4-bit code per sample tick.
// Define ADPCM_FEEDER_UNDERRUN_CNT_EN to build the saturating underrun tick counter.
module adpcm_nibble_feeder #(
  parameter int unsigned CLK_DIV     = 6250,
  parameter int unsigned DRAIN_TICKS = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       stop,
  adpcm_nibble_feeder_if.slave       feed,
  output logic [3:0]                 nibble,
  output logic                       nibble_stb,
  output logic                       dec_reset,
  output logic                       busy,
  output logic                       underrun,
  output logic [15:0]                underrun_cnt
);
  localparam int unsigned DIV_W   = 16;
  localparam int unsigned DRAIN_W = (DRAIN_TICKS > 1) ? $clog2(DRAIN_TICKS) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_PLAY, S_DRAIN} state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 clr_q, clr_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 buf_full_q, buf_full_d;
  logic                 buf_last_q, buf_last_d;
  logic                 phase_q, phase_d;
  logic [7:0]           buf_data_q, buf_data_d;
  logic                 byte_ready_q, byte_ready_d;
  logic [3:0]           nibble_d;
  logic                 stb_d, dec_reset_d, busy_d, underrun_d;
  logic                 tick, accept;
`ifdef ADPCM_FEEDER_UNDERRUN_CNT_EN
  logic [15:0]          ur_cnt_q, ur_cnt_d;
`endif

  assign tick            = (state_q != S_IDLE) && (div_q == DIV_LAST);
  assign accept          = feed.byte_valid && byte_ready_q;
  assign feed.byte_ready = byte_ready_q;

  // Next-state and next-output decode
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    clr_d      = clr_q;
    drain_d    = drain_q;
    buf_full_d = buf_full_q;
    buf_last_d = buf_last_q;
    buf_data_d = buf_data_q;
    phase_d    = phase_q;
    nibble_d   = nibble;
    stb_d      = 1'b0;
    underrun_d = underrun;
`ifdef ADPCM_FEEDER_UNDERRUN_CNT_EN
    ur_cnt_d   = ur_cnt_q;
`endif

    if (state_q != S_IDLE) div_d = tick ? '0 : DIV_W'(div_q + DIV_W'(1));

    if ((state_q == S_CLEAR || state_q == S_PLAY) && accept) begin
      buf_full_d = 1'b1;
      buf_data_d = feed.byte_data;
      buf_last_d = feed.byte_last;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d    = S_CLEAR;
          div_d      = '0;
          clr_d      = 1'b0;
          underrun_d = 1'b0;
`ifdef ADPCM_FEEDER_UNDERRUN_CNT_EN
          ur_cnt_d   = '0;
`endif
        end
      end
      S_CLEAR: begin
        if (tick) begin
          stb_d    = 1'b1;
          nibble_d = '0;
          clr_d    = 1'b1;
          if (clr_q) state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (tick) begin
          stb_d = 1'b1;
          if (phase_q) begin
            nibble_d   = buf_data_q[3:0];
            phase_d    = 1'b0;
            buf_full_d = 1'b0;
            if (buf_last_q) begin
              state_d = S_DRAIN;
              drain_d = '0;
            end
          end else if (buf_full_q) begin
            nibble_d = buf_data_q[7:4];
            phase_d  = 1'b1;
          end else begin
            nibble_d   = '0;
            underrun_d = 1'b1;
`ifdef ADPCM_FEEDER_UNDERRUN_CNT_EN
            if (ur_cnt_q != 16'hFFFF) ur_cnt_d = ur_cnt_q + 16'd1;
`endif
          end
        end
      end
      S_DRAIN: begin
        if (tick) begin
          stb_d    = 1'b1;
          nibble_d = '0;
          drain_d  = DRAIN_W'(drain_q + DRAIN_W'(1));
          if (drain_q == DRAIN_LAST) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort and restart override whatever the tick decided; stop beats start
    if (state_q != S_IDLE && (stop || start)) begin
      buf_full_d = 1'b0;
      buf_last_d = 1'b0;
      phase_d    = 1'b0;
      nibble_d   = '0;
      stb_d      = 1'b0;
      div_d      = '0;
      clr_d      = 1'b0;
      if (stop) begin
        state_d    = S_IDLE;
        underrun_d = underrun;
`ifdef ADPCM_FEEDER_UNDERRUN_CNT_EN
        ur_cnt_d   = ur_cnt_q;
`endif
      end else begin
        state_d    = S_CLEAR;
        underrun_d = 1'b0;
`ifdef ADPCM_FEEDER_UNDERRUN_CNT_EN
        ur_cnt_d   = '0;
`endif
      end
    end

    // dec_reset follows the state that produced a strobe so the decoder sees it aligned
    dec_reset_d  = stb_d ? (state_q == S_CLEAR) : (state_d == S_IDLE || state_d == S_CLEAR);
    busy_d       = (state_d != S_IDLE);
    byte_ready_d = (state_d == S_CLEAR || state_d == S_PLAY) && !buf_full_d;
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      clr_q        <= 1'b0;
      drain_q      <= '0;
      buf_full_q   <= 1'b0;
      buf_last_q   <= 1'b0;
      buf_data_q   <= '0;
      phase_q      <= 1'b0;
      byte_ready_q <= 1'b0;
      nibble       <= '0;
      nibble_stb   <= 1'b0;
      dec_reset    <= 1'b1;
      busy         <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      clr_q        <= clr_d;
      drain_q      <= drain_d;
      buf_full_q   <= buf_full_d;
      buf_last_q   <= buf_last_d;
      buf_data_q   <= buf_data_d;
      phase_q      <= phase_d;
      byte_ready_q <= byte_ready_d;
      nibble       <= nibble_d;
      nibble_stb   <= stb_d;
      dec_reset    <= dec_reset_d;
      busy         <= busy_d;
      underrun     <= underrun_d;
    end
  end

`ifdef ADPCM_FEEDER_UNDERRUN_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ur_cnt_q <= '0;
    else          ur_cnt_q <= ur_cnt_d;
  end
  assign underrun_cnt = ur_cnt_q;
`else
  assign underrun_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_adpcm_nibble_feeder.sv
// Randomized scoreboard bench for adpcm_nibble_feeder: expected strobe stream is
// derived per clip from the byte list and the number of starved ticks.
module tb_adpcm_nibble_feeder;
  localparam int unsigned CLK_DIV     = 4;
  localparam int unsigned DRAIN_TICKS = 4;
`ifdef ADPCM_FEEDER_UNDERRUN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed { logic [3:0] nib; logic drst; } exp_t;
  typedef struct packed { logic [7:0] d; logic last; } byte_t;

  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0, stop = 1'b0;
  logic [3:0]  nibble;
  logic        nibble_stb, dec_reset, busy, underrun;
  logic [15:0] underrun_cnt;

  exp_t       exp_q[$];
  byte_t      feed_q[$];
  logic [7:0] clip_bytes[$];
  bit         feed_en = 1'b0;
  int checks = 0, failures = 0;
  int cyc = 0, start_cyc = 0, last_stb = 0, rdy_cycles = 0;

  adpcm_nibble_feeder_if bif();

  adpcm_nibble_feeder #(.CLK_DIV(CLK_DIV), .DRAIN_TICKS(DRAIN_TICKS)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .feed(bif),
    .nibble(nibble), .nibble_stb(nibble_stb), .dec_reset(dec_reset), .busy(busy),
    .underrun(underrun), .underrun_cnt(underrun_cnt));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Byte source: presents the queue head whenever enabled; a pop marks the upcoming transfer
  initial begin : source
    bif.byte_valid = 1'b0; bif.byte_data = 8'h00; bif.byte_last = 1'b0;
    forever begin
      @(negedge clock);
      if (feed_en && feed_q.size() != 0) begin
        bif.byte_valid = 1'b1; bif.byte_data = feed_q[0].d; bif.byte_last = feed_q[0].last;
      end else begin
        bif.byte_valid = 1'b0; bif.byte_data = 8'($urandom); bif.byte_last = 1'($urandom);
      end
      if (bif.byte_valid && bif.byte_ready === 1'b1) void'(feed_q.pop_front());
    end
  end

  // Monitor: every strobe pops one expectation and must land CLK_DIV cycles after its predecessor
  initial begin : monitor
    exp_t e;
    int refc;
    forever begin
      @(negedge clock);
      if (bif.byte_ready === 1'b1) rdy_cycles++;
      if (nibble_stb === 1'b1) begin
        refc = (start_cyc > last_stb) ? start_cyc : last_stb;
        check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("nibble", 32'(nibble), 32'(e.nib));
          check("strobe_dec_reset", 32'(dec_reset), 32'(e.drst));
          check("tick_spacing", 32'(cyc - refc), 32'(CLK_DIV));
        end
        last_stb = cyc;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input logic [3:0] nib, input logic drst);
    exp_t e;
    e.nib = nib; e.drst = drst;
    exp_q.push_back(e);
  endtask

  task automatic wait_size(input int n);
    int k = 0;
    while (exp_q.size() > n && k < 600) begin
      @(negedge clock); #1;
      k++;
    end
    check("strobes_arrived", 32'(exp_q.size()), 32'(n));
    if (exp_q.size() > n) exp_q.delete();
  endtask

  task automatic do_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0; start_cyc = cyc;
    #1;
  endtask

  // Full clip: n_ur ticks of starvation after CLEAR, then clip_bytes, then drain
  task automatic run_clip(input int n_ur);
    byte_t b;
    int r0, total;
    feed_en = 1'b0; feed_q.delete();
    push_exp(4'h0, 1'b1); push_exp(4'h0, 1'b1);
    for (int i = 0; i < n_ur; i++) push_exp(4'h0, 1'b0);
    foreach (clip_bytes[i]) begin
      b.d = clip_bytes[i]; b.last = (i == clip_bytes.size() - 1);
      feed_q.push_back(b);
      push_exp(b.d[7:4], 1'b0); push_exp(b.d[3:0], 1'b0);
    end
    for (int i = 0; i < int'(DRAIN_TICKS); i++) push_exp(4'h0, 1'b0);
    total = exp_q.size();
    feed_en = (n_ur == 0);
    r0 = rdy_cycles;
    do_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_dec_reset", 32'(dec_reset), 32'd1);
    check("start_underrun", 32'(underrun), 32'd0);
    check("start_underrun_cnt", 32'(underrun_cnt), 32'd0);
    if (n_ur > 0) begin
      wait_size(total - 2 - n_ur);
      feed_en = 1'b1;
    end
    wait_size(0);
    @(negedge clock); #1;
    check("end_busy", 32'(busy), 32'd0);
    check("end_dec_reset", 32'(dec_reset), 32'd1);
    check("end_byte_ready", 32'(bif.byte_ready), 32'd0);
    check("end_underrun", 32'(underrun), 32'(n_ur > 0));
    check("end_underrun_cnt", 32'(underrun_cnt), CNT_EN ? 32'(n_ur) : 32'd0);
    if (n_ur == 0) check("ready_cycles", 32'(rdy_cycles - r0), 32'(clip_bytes.size()));
    feed_en = 1'b0;
  endtask

  initial begin : stimulus
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dec_reset", 32'(dec_reset), 32'd1);
    check("rst_byte_ready", 32'(bif.byte_ready), 32'd0);
    check("rst_stb", 32'(nibble_stb), 32'd0);
    check("rst_nibble", 32'(nibble), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_underrun_cnt", 32'(underrun_cnt), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    clip_bytes.delete(); clip_bytes.push_back(8'h3A); clip_bytes.push_back(8'h7C);
    run_clip(0);
    clip_bytes.delete(); clip_bytes.push_back(8'h5E);
    run_clip(3);
    clip_bytes.delete(); repeat (4) clip_bytes.push_back(8'h11);
    run_clip(0);
    for (int c = 0; c < 8; c++) begin
      clip_bytes.delete();
      repeat ($urandom_range(1, 6)) clip_bytes.push_back(8'($urandom));
      run_clip(($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 3)) : 0);
    end

    // Stop on the clock after the first PLAY strobe
    feed_q.delete(); exp_q.delete();
    clip_bytes.delete(); clip_bytes.push_back(8'h9B); clip_bytes.push_back(8'h42);
    feed_q.push_back(byte_t'({8'h9B, 1'b0})); feed_q.push_back(byte_t'({8'h42, 1'b1}));
    push_exp(4'h0, 1'b1); push_exp(4'h0, 1'b1); push_exp(4'h9, 1'b0);
    feed_en = 1'b1;
    do_start();
    wait_size(0);
    stop = 1'b1;
    @(negedge clock); stop = 1'b0; feed_en = 1'b0; feed_q.delete(); #1;
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_dec_reset", 32'(dec_reset), 32'd1);
    check("stop_byte_ready", 32'(bif.byte_ready), 32'd0);
    check("stop_nibble", 32'(nibble), 32'd0);
    repeat (4 * CLK_DIV) @(negedge clock);

    // Start and stop together during PLAY, then a plain start
    push_exp(4'h0, 1'b1); push_exp(4'h0, 1'b1); push_exp(4'h0, 1'b0);
    do_start();
    wait_size(0);
    check("starved_underrun", 32'(underrun), 32'd1);
    start = 1'b1; stop = 1'b1;
    @(negedge clock); start = 1'b0; stop = 1'b0; #1;
    check("startstop_busy", 32'(busy), 32'd0);
    check("startstop_underrun_kept", 32'(underrun), 32'd1);
    check("startstop_cnt_kept", 32'(underrun_cnt), CNT_EN ? 32'd1 : 32'd0);
    repeat (3 * CLK_DIV) @(negedge clock);
    clip_bytes.delete(); clip_bytes.push_back(8'hD6);
    run_clip(0);

    // Asynchronous reset between edges while PLAY holds a nibble and the underrun flag
    push_exp(4'h0, 1'b1); push_exp(4'h0, 1'b1); push_exp(4'h0, 1'b0); push_exp(4'hF, 1'b0);
    feed_q.push_back(byte_t'({8'hF5, 1'b1}));
    do_start();
    wait_size(1);
    feed_en = 1'b1;
    wait_size(0);
    @(posedge clock); #2;
    reset_n = 1'b0; #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_dec_reset", 32'(dec_reset), 32'd1);
    check("arst_byte_ready", 32'(bif.byte_ready), 32'd0);
    check("arst_stb", 32'(nibble_stb), 32'd0);
    check("arst_nibble", 32'(nibble), 32'd0);
    check("arst_underrun", 32'(underrun), 32'd0);
    check("arst_underrun_cnt", 32'(underrun_cnt), 32'd0);
    feed_en = 1'b0; feed_q.delete(); exp_q.delete();
    @(negedge clock); reset_n = 1'b1;
    repeat (2) @(negedge clock);
    clip_bytes.delete(); clip_bytes.push_back(8'h28); clip_bytes.push_back(8'hE1);
    run_clip(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adpcm_nibble_feeder.md
ADPCM_NIBBLE_FEEDER -- requirements
Module: adpcm_nibble_feeder

Interface
REQ-001 Parameter CLK_DIV, default 6250, system clocks per sample tick (50 MHz / 8 kHz); legal range 4..65535.
REQ-002 Parameter DRAIN_TICKS, default 4, sample ticks held busy after the last nibble so the downstream decoder pipeline flushes.
REQ-003 clock  input  1  system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset; deassertion is synchronous to clock.
REQ-005 start  input  1  one-cycle pulse that begins a new clip.
REQ-006 stop  input  1  one-cycle pulse that aborts the clip.
REQ-007 byte_data  input  8  packed ADPCM byte: two 4-bit codes, high nibble played first.
REQ-008 byte_valid  input  1  byte_data/byte_last valid.
REQ-009 byte_last  input  1  current byte is the final byte of the clip.
REQ-010 byte_ready  output  1  feeder accepts a byte this cycle; transfer occurs when byte_valid && byte_ready.
REQ-011 nibble  output  4  ADPCM code for the downstream decoder, registered, held between ticks.
REQ-012 nibble_stb  output  1  one-clock pulse marking a new nibble; the decoder advances on it.
REQ-013 dec_reset  output  1  active-high synchronous reset for the downstream decoder.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 underrun  output  1  sticky flag: a nibble was needed while the byte buffer was empty.
REQ-016 underrun_cnt  output  16  count of underrun ticks (see Configuration).

Function
REQ-017 States IDLE, CLEAR, PLAY, DRAIN; the encoding is free.
REQ-018 Tick divider counts 0..CLK_DIV-1 outside IDLE and is cleared to 0 on entry to CLEAR; a tick is the cycle where count == CLK_DIV-1.
REQ-019 IDLE: dec_reset=1, byte_ready=0, nibble_stb=0; start -> CLEAR.
REQ-020 CLEAR: dec_reset=1 and nibble_stb pulses on each of exactly 2 ticks (nibble=0) so the decoder samples its reset; after the 2nd tick -> PLAY.
REQ-021 One-byte holding buffer with a nibble phase bit; byte_ready = buffer empty, in CLEAR or PLAY only.
REQ-022 PLAY, on each tick: nibble_stb=1; phase 0 with buffer full -> nibble=byte[7:4], phase=1; phase 1 -> nibble=byte[3:0], phase=0, buffer emptied.
REQ-023 PLAY, tick at phase 0 with buffer empty -> nibble=4'b0000, underrun set, phase unchanged.
REQ-024 Low nibble of a byte tagged byte_last emitted -> DRAIN on the same tick; byte_ready=0 in DRAIN.
REQ-025 DRAIN: nibble_stb on each tick with nibble=0, dec_reset=0; after DRAIN_TICKS ticks -> IDLE.
REQ-026 A byte may be accepted in the same cycle the buffer empties only from the following cycle (no bypass); byte_ready never asserts combinationally from byte_valid.
REQ-027 stop in any non-IDLE state -> IDLE next cycle, buffer flushed, phase=0, nibble=0.
REQ-028 start in a non-IDLE state restarts: -> CLEAR, buffer flushed, divider cleared.
REQ-029 stop and start in the same cycle: stop wins.
REQ-030 underrun and underrun_cnt clear on start; both otherwise persist across IDLE.

Reset
REQ-031 reset_n low: state=IDLE, divider=0, buffer empty, phase=0, nibble=0, nibble_stb=0, dec_reset=1, busy=0, byte_ready=0, underrun=0, underrun_cnt=0.
REQ-032 Reset mid-clip discards all buffered data; there is no resume.

Configuration
REQ-033 Macro ADPCM_FEEDER_UNDERRUN_CNT_EN defined: underrun_cnt increments on every underrun tick, saturating at 16'hFFFF.
REQ-034 Macro undefined: underrun_cnt tied to 16'd0 and no counter logic present; the underrun flag is unaffected.

Verification (CLK_DIV=4, DRAIN_TICKS=4)
REQ-035 start, bytes 8'h3A, 8'h7C (last) always valid -> after 2 CLEAR strobes, nibbles 3,A,7,C on successive ticks 4 clocks apart, then 4 strobes of 0, busy falls.
REQ-036 start, no byte offered for 3 ticks of PLAY -> 3 strobes with nibble 0, underrun=1, underrun_cnt=3 (macro on) or 0 (macro off).
REQ-037 stop on the clock after the 1st PLAY strobe -> next cycle busy=0, dec_reset=1, byte_ready=0, no further strobes.
REQ-038 start and stop in the same cycle during PLAY -> IDLE; a later start alone -> CLEAR with underrun cleared.
REQ-039 reset_n pulled low between clock edges during PLAY -> outputs reach reset values immediately, without a clock edge.
REQ-040 byte_valid held high with 8'h11 every cycle -> byte_ready high at most one cycle per two ticks; every strobe delivers nibble 1.
